// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter sharing dat_mem between the core (port 0) and the host loader (port 1).
// Grants are registered; the owner may lock for a burst bounded by MAXBURST while the other port waits.
module dm_arbiter #(
    parameter int D        = 8,
    parameter int W        = 8,
    parameter int MAXBURST = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Req0,
    input  logic         We0,
    input  logic         Lock0,
    input  logic [D-1:0] Addr0,
    input  logic [W-1:0] Wdata0,
    output logic         Gnt0,
    output logic [W-1:0] Rdata0,
    output logic         Rvalid0,
    output logic         Stall0,
    input  logic         Req1,
    input  logic         We1,
    input  logic         Lock1,
    input  logic [D-1:0] Addr1,
    input  logic [W-1:0] Wdata1,
    output logic         Gnt1,
    output logic [W-1:0] Rdata1,
    output logic         Rvalid1,
    output logic [D-1:0] MemAddr,
    output logic         MemWe,
    output logic [W-1:0] MemWdata,
    input  logic [W-1:0] MemRdata
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam logic [8:0] BurstLimit = 9'(MAXBURST);

    state_t         stateR, stateS, otherS;
    logic           lastR, lastS;
    logic [7:0]     bcR, bcS, bcIncS;
    logic           gnt0R, gnt1R;
    logic           rvalid0R, rvalid1R;
    logic [W-1:0]   rdata0R, rdata1R;
    logic           reqOwnS, weOwnS, lockOwnS, reqOtherS;
    logic           releaseS, burstDoneS;
    logic           rdAcc0S, rdAcc1S;
    logic [D-1:0]   memAddrS;
    logic [W-1:0]   memWdataS;
    logic           memWeS;

    // Route the owning port onto the memory bus and pick out its control bits
    always_comb begin
        reqOwnS   = 1'b0;
        weOwnS    = 1'b0;
        lockOwnS  = 1'b0;
        reqOtherS = 1'b0;
        otherS    = IDLE;
        memAddrS  = {D{1'b0}};
        memWdataS = {W{1'b0}};
        case (stateR)
            OWN0: begin
                reqOwnS   = Req0;
                weOwnS    = We0;
                lockOwnS  = Lock0;
                reqOtherS = Req1;
                otherS    = OWN1;
                memAddrS  = Addr0;
                memWdataS = Wdata0;
            end
            OWN1: begin
                reqOwnS   = Req1;
                weOwnS    = We1;
                lockOwnS  = Lock1;
                reqOtherS = Req0;
                otherS    = OWN0;
                memAddrS  = Addr1;
                memWdataS = Wdata1;
            end
            default: otherS = IDLE;
        endcase
        memWeS = reqOwnS & weOwnS;
    end

    // Next owner, last-served pointer and saturating burst count
    always_comb begin
        stateS     = stateR;
        lastS      = lastR;
        bcS        = bcR;
        bcIncS     = ({1'b0, bcR} >= BurstLimit) ? bcR : bcR + 8'd1;
        burstDoneS = ({1'b0, bcR} + 9'd1) >= BurstLimit;
        releaseS   = ~reqOwnS | ~lockOwnS | (burstDoneS & reqOtherS);
        if (stateR == IDLE) begin
            bcS = 8'd0;
            if (Req0 & Req1) begin
                stateS = lastR ? OWN0 : OWN1;
            end else if (Req0) begin
                stateS = OWN0;
            end else if (Req1) begin
                stateS = OWN1;
            end else begin
                stateS = IDLE;
            end
        end else begin
            if (reqOwnS) begin
                bcS = bcIncS;
            end else begin
                bcS = bcR;
            end
            if (releaseS) begin
                lastS = (stateR == OWN1);
                if (reqOtherS) begin
                    stateS = otherS;
                    bcS    = 8'd0;
                end else if (reqOwnS & ~lockOwnS) begin
                    // unlocked requester with no competitor keeps the bus without a bubble
                    stateS = stateR;
                end else begin
                    stateS = IDLE;
                    bcS    = 8'd0;
                end
            end else begin
                stateS = stateR;
            end
        end
    end

    // Arbitration state and registered grants
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stateR <= IDLE;
            lastR  <= 1'b1;
            bcR    <= 8'd0;
            gnt0R  <= 1'b0;
            gnt1R  <= 1'b0;
        end else begin
            stateR <= stateS;
            lastR  <= lastS;
            bcR    <= bcS;
            gnt0R  <= (stateS == OWN0);
            gnt1R  <= (stateS == OWN1);
        end
    end

    assign rdAcc0S = (stateR == OWN0) & Req0 & ~We0;
    assign rdAcc1S = (stateR == OWN1) & Req1 & ~We1;

    // Capture read data for the owner and pulse its valid for one cycle
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rvalid0R <= 1'b0;
            rvalid1R <= 1'b0;
            rdata0R  <= {W{1'b0}};
            rdata1R  <= {W{1'b0}};
        end else begin
            rvalid0R <= rdAcc0S;
            rvalid1R <= rdAcc1S;
            if (rdAcc0S) begin
                rdata0R <= MemRdata;
            end else begin
                rdata0R <= rdata0R;
            end
            if (rdAcc1S) begin
                rdata1R <= MemRdata;
            end else begin
                rdata1R <= rdata1R;
            end
        end
    end

    assign Gnt0     = gnt0R;
    assign Gnt1     = gnt1R;
    assign Rvalid0  = rvalid0R;
    assign Rvalid1  = rvalid1R;
    assign Rdata0   = rdata0R;
    assign Rdata1   = rdata1R;
    assign Stall0   = Req0 & ~gnt0R;
    assign MemAddr  = memAddrS;
    assign MemWe    = memWeS;
    assign MemWdata = memWdataS;
endmodule
